// File: rtl/game2048_pkg.sv
// game2048_pkg: shared types and constants for the 2048 game core.
//   TILE_W_DFLT   default tile width in bits (tile holds its literal value)
//   tile_t        one tile at the default width
//   TILE_EMPTY/TILE_TWO/TILE_FOUR  tile values used by the spawner
//   spawn_state_t tile_spawner control states
package game2048_pkg;

    localparam int TILE_W_DFLT = 12;

    typedef logic [TILE_W_DFLT-1:0] tile_t;

    localparam int TILE_EMPTY = 0;
    localparam int TILE_TWO   = 2;
    localparam int TILE_FOUR  = 4;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        SELECT,
        WRITE,
        DONE
    } spawn_state_t;

endpackage

// File: rtl/tile_spawner_lfsr_gen.sv
// lfsr_gen: free-running Galois LFSR (right-shifting) with synchronous load.
//   clk, rst_n  clock, async active-low reset (state returns to SEED)
//   load        load q from load_val this cycle (wins over stepping)
//   load_val    value to load; zero is replaced by 1 so the LFSR never locks up
//   q           current LFSR state
module lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    // Maximal-length feedback masks for the supported widths.
    function automatic logic [WIDTH-1:0] tap_mask();
        logic [63:0] t;
        case (WIDTH)
            8:       t = 64'h0000_00B8;
            12:      t = 64'h0000_0E08;
            16:      t = 64'h0000_B400;
            20:      t = 64'h0009_0000;
            24:      t = 64'h00E1_0000;
            32:      t = 64'h8020_0003;
            default: t = 64'h1 << (WIDTH - 1);
        endcase
        return t[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] TAPS = tap_mask();

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        if (load) begin
            lfsr_d = (load_val == '0) ? WIDTH'(1) : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tile_spawner.sv
// tile_spawner: places one new tile on a uniformly chosen empty cell of an
// NxN 2048 board. Fixed latency: done is sampled high on the 2*N*N+2'th
// clock edge after the start edge.
//   clk, rst_n          clock, async active-low reset
//   start               spawn request, sampled only when idle
//   board_in            board snapshot, cell index = row*N + col
//   seed_we, seed_in    reload the LFSR (zero loads as 1)
//   board_out           result board (held until the next spawn writes it)
//   spawn_row/col/val   placed cell and value (all zero when full)
//   full                board had no empty cell; valid with done
//   busy                high whenever not idle
//   done                one-cycle result-valid pulse
// Optional build macro: TILE_SPAWN_FOUR_EN -- spawned tile is 4 with
// probability FOUR_NUM/16, otherwise always 2.
module tile_spawner
    import game2048_pkg::*;
#(
    parameter int                N        = 4,
    parameter int                TILE_W   = TILE_W_DFLT,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(16'hACE1),
    parameter int                FOUR_NUM = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N*N-1:0][TILE_W-1:0]    board_in,
    input  logic                          seed_we,
    input  logic [LFSR_W-1:0]             seed_in,
    output logic [N*N-1:0][TILE_W-1:0]    board_out,
    output logic [$clog2(N)-1:0]          spawn_row,
    output logic [$clog2(N)-1:0]          spawn_col,
    output logic [TILE_W-1:0]             spawn_val,
    output logic                          full,
    output logic                          busy,
    output logic                          done
);

    localparam int CELLS = N * N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RC_W  = $clog2(N);

    spawn_state_t                    state_q, state_d;
    logic [CELLS-1:0][TILE_W-1:0]    board_cap_q, board_cap_d;
    logic [IDX_W-1:0]                cell_idx_q, cell_idx_d;
    logic [IDX_W:0]                  empty_cnt_q, empty_cnt_d;
    logic [IDX_W:0]                  target_q, target_d;
    logic [IDX_W:0]                  run_idx_q, run_idx_d;
    logic [IDX_W-1:0]                sel_idx_q, sel_idx_d;
    logic [CELLS-1:0][TILE_W-1:0]    board_out_q, board_out_d;
    logic [RC_W-1:0]                 spawn_row_q, spawn_row_d;
    logic [RC_W-1:0]                 spawn_col_q, spawn_col_d;
    logic [TILE_W-1:0]               spawn_val_q, spawn_val_d;
    logic                            full_q, full_d;
`ifdef TILE_SPAWN_FOUR_EN
    logic                            four_q, four_d;
`else
    localparam int unused_four_num = FOUR_NUM;
`endif

    logic [LFSR_W-1:0]               lfsr_q;
    logic                            cur_empty;
    logic                            last_cell;
    logic [IDX_W:0]                  cnt_final;
    logic [2*IDX_W:0]                prod;
    logic [TILE_W-1:0]               new_val;
    logic                            unused_lfsr_bits;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_we),
        .load_val (seed_in),
        .q        (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:IDX_W];

    assign cur_empty = (board_cap_q[cell_idx_q] == TILE_W'(TILE_EMPTY));
    assign last_cell = (cell_idx_q == IDX_W'(CELLS - 1));
    // Count including the cell visited this cycle, so the last cell counts.
    assign cnt_final = empty_cnt_q + {{IDX_W{1'b0}}, cur_empty};
    // Scale an IDX_W-bit random fraction onto 0..cnt_final-1.
    assign prod = {{(IDX_W+1){1'b0}}, lfsr_q[IDX_W-1:0]} * {{IDX_W{1'b0}}, cnt_final};

`ifdef TILE_SPAWN_FOUR_EN
    assign new_val = four_q ? TILE_W'(TILE_FOUR) : TILE_W'(TILE_TWO);
`else
    assign new_val = TILE_W'(TILE_TWO);
`endif

    always_comb begin
        state_d     = state_q;
        board_cap_d = board_cap_q;
        cell_idx_d  = cell_idx_q;
        empty_cnt_d = empty_cnt_q;
        target_d    = target_q;
        run_idx_d   = run_idx_q;
        sel_idx_d   = sel_idx_q;
        board_out_d = board_out_q;
        spawn_row_d = spawn_row_q;
        spawn_col_d = spawn_col_q;
        spawn_val_d = spawn_val_q;
        full_d      = full_q;
`ifdef TILE_SPAWN_FOUR_EN
        four_d      = four_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    board_cap_d = board_in;
                    empty_cnt_d = '0;
                    cell_idx_d  = '0;
                    state_d     = COUNT;
                end
            end
            COUNT: begin
                empty_cnt_d = cnt_final;
                cell_idx_d  = cell_idx_q + IDX_W'(1);
                if (last_cell) begin
                    target_d   = prod[2*IDX_W:IDX_W];
`ifdef TILE_SPAWN_FOUR_EN
                    four_d     = (int'(lfsr_q[LFSR_W-1 -: 4]) < FOUR_NUM);
`endif
                    cell_idx_d = '0;
                    run_idx_d  = '0;
                    sel_idx_d  = '0;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                // Full scan regardless of when the target is found keeps latency fixed.
                if (cur_empty) begin
                    if (run_idx_q == target_q) begin
                        sel_idx_d = cell_idx_q;
                    end
                    run_idx_d = run_idx_q + (IDX_W+1)'(1);
                end
                cell_idx_d = cell_idx_q + IDX_W'(1);
                if (last_cell) begin
                    cell_idx_d = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                board_out_d = board_cap_q;
                if (empty_cnt_q == '0) begin
                    full_d      = 1'b1;
                    spawn_val_d = '0;
                    spawn_row_d = '0;
                    spawn_col_d = '0;
                end else begin
                    full_d                 = 1'b0;
                    spawn_val_d            = new_val;
                    spawn_row_d            = RC_W'(int'(sel_idx_q) / N);
                    spawn_col_d            = RC_W'(int'(sel_idx_q) % N);
                    board_out_d[sel_idx_q] = new_val;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cell_idx_q  <= '0;
            empty_cnt_q <= '0;
            target_q    <= '0;
            run_idx_q   <= '0;
            sel_idx_q   <= '0;
            board_out_q <= '0;
            spawn_row_q <= '0;
            spawn_col_q <= '0;
            spawn_val_q <= '0;
            full_q      <= 1'b0;
`ifdef TILE_SPAWN_FOUR_EN
            four_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cell_idx_q  <= cell_idx_d;
            empty_cnt_q <= empty_cnt_d;
            target_q    <= target_d;
            run_idx_q   <= run_idx_d;
            sel_idx_q   <= sel_idx_d;
            board_out_q <= board_out_d;
            spawn_row_q <= spawn_row_d;
            spawn_col_q <= spawn_col_d;
            spawn_val_q <= spawn_val_d;
            full_q      <= full_d;
`ifdef TILE_SPAWN_FOUR_EN
            four_q      <= four_d;
`endif
        end
    end

    // Captured snapshot is only read after a start, so it needs no reset.
    always_ff @(posedge clk) begin
        board_cap_q <= board_cap_d;
    end

    assign board_out = board_out_q;
    assign spawn_row = spawn_row_q;
    assign spawn_col = spawn_col_q;
    assign spawn_val = spawn_val_q;
    assign full      = full_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: randomized bench for tile_spawner (N=4) with a reference
// model of the LFSR sequence and of the uniform empty-cell choice.
module tb_tile_spawner;

    localparam int          N        = 4;
    localparam int          TILE_W   = 12;
    localparam int          LFSR_W   = 16;
    localparam int          CELLS    = N * N;
    localparam int          FOUR_NUM = 2;
    localparam int          LATENCY  = 2 * CELLS + 2;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [15:0] TAPS     = 16'hB400;

    typedef logic [CELLS-1:0][TILE_W-1:0] board_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              seed_we = 1'b0;
    logic [LFSR_W-1:0] seed_in = '0;
    board_t            board_in = '0;
    board_t            board_out;
    logic [1:0]        spawn_row, spawn_col;
    logic [TILE_W-1:0] spawn_val;
    logic              full, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int hist [CELLS];

    tile_spawner #(
        .N(N), .TILE_W(TILE_W), .LFSR_W(LFSR_W), .SEED(SEED), .FOUR_NUM(FOUR_NUM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in),
        .seed_we(seed_we), .seed_in(seed_in), .board_out(board_out),
        .spawn_row(spawn_row), .spawn_col(spawn_col), .spawn_val(spawn_val),
        .full(full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Galois right shift, steps every cycle, reload wins.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        m_lfsr <= SEED;
        else if (seed_we)  m_lfsr <= (seed_in == 16'd0) ? 16'd1 : seed_in;
        else               m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 16'd0);
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One spawn: start on a fresh cycle, wait for done, compare with the model.
    task automatic run_spawn(input board_t b, input bit repulse, output int chosen);
        board_t      cap, exp_board;
        logic [15:0] r;
        int          done_k, done_n, cnt, tgt, k_idx, exp_idx, exp_val;
        r = '0; done_k = 0; done_n = 0; exp_idx = -1;
        @(negedge clk);
        board_in = b;
        cap      = b;
        start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= LATENCY + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                board_in = {6{$urandom()}};
                check_eq("busy_after_start", busy, 1);
            end
            if (repulse && (k == 5 || k == 20)) start = 1'b1;
            if (repulse && (k == 6 || k == 21)) start = 1'b0;
            if (k == CELLS) r = m_lfsr;
            if (done) begin
                done_n++;
                if (done_k == 0) begin
                    done_k = k;
                    check_eq("busy_in_done", busy, 1);
                end
            end
            if (done_k != 0 && !repulse) break;
        end
        check_eq("done_latency", done_k, LATENCY);
        if (repulse) check_eq("done_pulses", done_n, 1);

        cnt = 0;
        for (int i = 0; i < CELLS; i++) if (cap[i] == '0) cnt++;
        exp_board = cap;
        if (cnt == 0) begin
            check_eq("full_flag", full, 1);
            check_eq("val_full", spawn_val, 0);
            check_eq("row_full", spawn_row, 0);
            check_eq("col_full", spawn_col, 0);
        end else begin
            tgt   = (int'(r[3:0]) * cnt) >> 4;
            k_idx = 0;
            for (int i = 0; i < CELLS; i++) begin
                if (cap[i] == '0) begin
                    if (k_idx == tgt) exp_idx = i;
                    k_idx++;
                end
            end
`ifdef TILE_SPAWN_FOUR_EN
            exp_val = (int'(r[15:12]) < FOUR_NUM) ? 4 : 2;
`else
            exp_val = 2;
`endif
            exp_board[exp_idx] = TILE_W'(exp_val);
            check_eq("full_flag", full, 0);
            check_eq("spawn_val", spawn_val, exp_val);
            check_eq("spawn_row", spawn_row, exp_idx / N);
            check_eq("spawn_col", spawn_col, exp_idx % N);
        end
        check_eq("board_out", board_out, exp_board);
        chosen = exp_idx;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        board_t b;
        int     ch;

        for (int i = 0; i < CELLS; i++) hist[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_board", board_out, 0);
        check_eq("rst_rowcolval", {spawn_row, spawn_col, spawn_val}, 0);
        check_eq("rst_lfsr", dut.u_lfsr.q, SEED);
        rst_n = 1'b1;

        // All-zero board
        run_spawn('0, 1'b0, ch);

        // Full board of 8s
        for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(8);
        run_spawn(b, 1'b0, ch);

        // Single hole at (2,1), many seeds
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            seed_in = 16'($urandom());
            seed_we = 1'b1;
            @(negedge clk);
            seed_we = 1'b0;
            for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(8 << (i % 3));
            b[2*N+1] = '0;
            run_spawn(b, 1'b0, ch);
            check_eq("hole_idx", ch, 2*N+1);
        end

        // Random boards, some cells empty
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < CELLS; i++)
                b[i] = ($urandom_range(0, 1) == 0) ? '0 : TILE_W'(2 << $urandom_range(0, 9));
            run_spawn(b, 1'b0, ch);
        end

        // Re-pulsed start is ignored
        run_spawn('0, 1'b1, ch);

        // Reset in the middle of a run
        @(negedge clk);
        board_in = '0;
        start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {done, busy, full, spawn_row, spawn_col, spawn_val}, 0);
        check_eq("midrst_board", board_out, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        run_spawn('0, 1'b0, ch);

        // Zero seed loads as 1
        @(negedge clk);
        seed_in = '0;
        seed_we = 1'b1;
        @(negedge clk);
        seed_we = 1'b0;
        check_eq("seed_zero_lfsr", dut.u_lfsr.q, 1);
        run_spawn('0, 1'b0, ch);
        check_eq("seed_zero_valid", (ch >= 0 && ch < CELLS), 1);

        // Distribution over an empty board
        for (int t = 0; t < 1600; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_spawn('0, 1'b0, ch);
            if (ch >= 0) hist[ch]++;
        end
        for (int i = 0; i < CELLS; i++)
            check_eq($sformatf("hist_cell%0d", i), (hist[i] >= 50 && hist[i] <= 150), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
